// File: rtl/scarv_cop_issue_pkg.sv
// Shared definitions for the CPU-side coprocessor issue block:
// status codes, response-entry layout and default sizing.
package scarv_cop_issue_pkg;

   localparam logic [2:0] SCARV_COP_STATUS_OK      = 3'd0;
   localparam logic [2:0] SCARV_COP_STATUS_TIMEOUT = 3'd7;

   localparam int DEFAULT_DEPTH   = 4;
   localparam int DEFAULT_TIMEOUT = 255;

   // One completed instruction waiting for the host: rd + wen + wdata + status.
   typedef struct packed {
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] wdata;
      logic [2:0]  status;
   } rsp_entry_t;

   localparam int RSP_W = $bits(rsp_entry_t);   // 5+1+32+3 = 41

endpackage

// File: rtl/scarv_cop_cpu_issue_if.sv
// Host/coprocessor signal bundle of the issue block.
// master: the issue block itself; slave: the host pipeline plus coprocessor.
interface scarv_cop_cpu_issue_if;

   // Host request channel
   logic        cpu_req_valid;
   logic        cpu_req_ready;
   logic [31:0] cpu_req_insn;
   logic [31:0] cpu_req_rs1;
   logic [4:0]  cpu_req_rd;

   // Coprocessor instruction channel
   logic        cop_insn_req;
   logic        cop_insn_ack;
   logic [31:0] cop_insn_enc;
   logic [31:0] cop_insn_rs1;

   // Coprocessor response channel
   logic        cop_insn_rsp;
   logic [2:0]  cop_insn_status;
   logic        cop_wen;
   logic [31:0] cop_wdata;

   // Host response channel
   logic        cpu_rsp_valid;
   logic        cpu_rsp_ready;
   logic [4:0]  cpu_rsp_rd;
   logic        cpu_rsp_wen;
   logic [31:0] cpu_rsp_wdata;
   logic [2:0]  cpu_rsp_status;

   modport master (
      input  cpu_req_valid, cpu_req_insn, cpu_req_rs1, cpu_req_rd,
      input  cop_insn_ack,
      input  cop_insn_rsp, cop_insn_status, cop_wen, cop_wdata,
      input  cpu_rsp_ready,
      output cpu_req_ready,
      output cop_insn_req, cop_insn_enc, cop_insn_rs1,
      output cpu_rsp_valid, cpu_rsp_rd, cpu_rsp_wen, cpu_rsp_wdata, cpu_rsp_status
   );

   modport slave (
      output cpu_req_valid, cpu_req_insn, cpu_req_rs1, cpu_req_rd,
      output cop_insn_ack,
      output cop_insn_rsp, cop_insn_status, cop_wen, cop_wdata,
      output cpu_rsp_ready,
      input  cpu_req_ready,
      input  cop_insn_req, cop_insn_enc, cop_insn_rs1,
      input  cpu_rsp_valid, cpu_rsp_rd, cpu_rsp_wen, cpu_rsp_wdata, cpu_rsp_status
   );

endinterface

// File: rtl/scarv_cop_issue_fifo.sv
// Small synchronous FIFO used for the GPR tag queue and the response queue.
// DEPTH must be a power of two >= 2; pointers wrap naturally, occupancy is
// tracked in a count one bit wider than the pointers. Push and pop in the
// same cycle both take effect (also when full).
module scarv_cop_issue_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             g_clk,
   input  logic             g_resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage.
   // NOTE: storage has no reset; validity comes from count, and consumers
   // must ignore head while empty.
   always_ff @(posedge g_clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/scarv_cop_cpu_issue.sv
// CPU-side initiator of the coprocessor instruction interface.
// Registers host ISE instructions, issues them over req/ack, records the GPR
// destination of each acked instruction in a tag FIFO, pairs in-order
// coprocessor responses with those tags and queues the results for the host.
// Optional build macro SCARV_COP_ISSUE_TIMEOUT_EN: a wait counter retires the
// oldest in-flight instruction with status TIMEOUT after TIMEOUT cycles and
// discards the matching late response.
module scarv_cop_cpu_issue
   import scarv_cop_issue_pkg::*;
#(
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,
   scarv_cop_cpu_issue_if.master bus,
   output logic                  busy,
   output logic                  err_spurious
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Issue register
   logic        req_q;
   logic [31:0] enc_q;
   logic [31:0] rs1_q;
   logic [4:0]  rd_q;

   logic             req_fire;
   logic             ack_fire;
   logic             rsp_pop;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W:0]   occupancy;

   // Tag / response queues
   logic       tag_empty;
   logic       tag_pop;
   logic [4:0] tag_head;
   logic       rsp_empty;
   logic       rsp_match;
   logic       late_pending;
   logic       timeout_fire;
   rsp_entry_t rsp_in;
   rsp_entry_t rsp_head;
   logic       unused_tag_full;
   logic       unused_rsp_full;

   assign req_fire  = bus.cpu_req_valid && bus.cpu_req_ready;
   assign ack_fire  = req_q && bus.cop_insn_ack;
   assign rsp_pop   = !rsp_empty && bus.cpu_rsp_ready;
   assign rsp_match = bus.cop_insn_rsp && !tag_empty;
   assign tag_pop   = (rsp_match && !late_pending) || timeout_fire;

   // Ready only if the issue slot frees this cycle and one more instruction
   // cannot push acked-but-unconsumed work past DEPTH.
   assign occupancy         = {1'b0, inflight} + {{CNT_W{1'b0}}, req_q};
   assign bus.cpu_req_ready = (!req_q || bus.cop_insn_ack) && (occupancy < (CNT_W+1)'(DEPTH));

   assign bus.cop_insn_req = req_q;
   assign bus.cop_insn_enc = enc_q;
   assign bus.cop_insn_rs1 = rs1_q;

   // Issue register: capture on host accept, hold stable until the coprocessor acks.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         req_q <= 1'b0;
         enc_q <= '0;
         rs1_q <= '0;
         rd_q  <= '0;
      end else if (req_fire) begin
         req_q <= 1'b1;
         enc_q <= bus.cpu_req_insn;
         rs1_q <= bus.cpu_req_rs1;
         rd_q  <= bus.cpu_req_rd;
      end else if (ack_fire) begin
         req_q <= 1'b0;
      end
   end

   // In-flight count: acked instructions not yet consumed by the host.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         inflight <= '0;
      end else begin
         case ({ack_fire, rsp_pop})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

   // Sticky flag for a response that had no instruction to pair with.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         err_spurious <= 1'b0;
      end else if (bus.cop_insn_rsp && tag_empty) begin
         err_spurious <= 1'b1;
      end
   end

   // Response FIFO entry: the real coprocessor result, or a timeout stand-in.
   // NOTE: every always_comb output gets a full default first so no path
   // leaves it unassigned and infers a latch.
   always_comb begin
      rsp_in = '{rd: tag_head, wen: bus.cop_wen, wdata: bus.cop_wdata,
                 status: bus.cop_insn_status};
      if (timeout_fire) begin
         rsp_in.wen    = 1'b0;
         rsp_in.wdata  = '0;
         rsp_in.status = SCARV_COP_STATUS_TIMEOUT;
      end
   end

`ifdef SCARV_COP_ISSUE_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int LATE_W = 8;

   logic [WAIT_W-1:0] wait_cnt;
   logic [LATE_W-1:0] late_cnt;
   logic              late_dec;

   assign late_pending = (late_cnt != '0);
   assign late_dec     = rsp_match && late_pending;
   // A response arriving in the expiry cycle always takes priority.
   assign timeout_fire = !tag_empty && !bus.cop_insn_rsp &&
                         (wait_cnt >= WAIT_W'(TIMEOUT - 1));

   // Age of the oldest in-flight instruction; restarts whenever the head changes.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         wait_cnt <= '0;
      end else if (tag_pop || tag_empty) begin
         wait_cnt <= '0;
      end else if (wait_cnt < WAIT_W'(TIMEOUT - 1)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Responses still owed for instructions already retired by timeout.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         late_cnt <= '0;
      end else if (timeout_fire) begin
         if (late_cnt != '1) late_cnt <= late_cnt + 1'b1;
      end else if (late_dec) begin
         late_cnt <= late_cnt - 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign late_pending   = 1'b0;
   assign timeout_fire   = 1'b0;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   scarv_cop_issue_fifo #(
      .WIDTH (5),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .push      (ack_fire),
      .push_data (rd_q),
      .pop       (tag_pop),
      .head      (tag_head),
      .empty     (tag_empty),
      .full      (unused_tag_full)
   );

   scarv_cop_issue_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (DEPTH)
   ) u_rsp_fifo (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .push      (tag_pop),
      .push_data (rsp_in),
      .pop       (rsp_pop),
      .head      (rsp_head),
      .empty     (rsp_empty),
      .full      (unused_rsp_full)
   );

   // Head of the response queue, forced to zero while nothing is queued.
   assign bus.cpu_rsp_valid  = !rsp_empty;
   assign bus.cpu_rsp_rd     = rsp_empty ? '0   : rsp_head.rd;
   assign bus.cpu_rsp_wen    = rsp_empty ? 1'b0 : rsp_head.wen;
   assign bus.cpu_rsp_wdata  = rsp_empty ? '0   : rsp_head.wdata;
   assign bus.cpu_rsp_status = rsp_empty ? '0   : rsp_head.status;

   assign busy = req_q || (inflight != '0);

endmodule
